// File: rtl/paddle_position_ctrl.sv
// Per-player paddle position integrator and PAD_OUT line-count timer.
// Optional hold acceleration is enabled with `define PADDLE_ACCEL_EN.
module paddle_position_ctrl #(
  parameter logic [7:0] CENTER    = 8'd114,
  parameter logic [3:0] STEP_SLOW = 4'd4,
  parameter logic [3:0] STEP_FAST = 4'd8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       pad_en_n,
  input  logic       player2,
  input  logic       speed,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p2_left,
  input  logic       p2_right,
  input  logic [1:0] p1_mode,
  input  logic [1:0] p2_mode,
  input  logic [7:0] p1_abs,
  input  logic [7:0] p2_abs,
  output logic       pad_out,
  output logic [7:0] p1_pos,
  output logic [7:0] p2_pos
);

  logic       hsync_q;
  logic       vsync_q;
  logic       hs_rise;
  logic       vs_rise;
  logic [7:0] line_cnt;
  logic [7:0] latched_pos;

  logic       act_left;
  logic       act_right;
  logic [1:0] act_mode;
  logic [7:0] act_abs;
  logic [7:0] act_pos;
  logic [7:0] target;
  logic [4:0] base_step;
  logic [4:0] step;
  logic [8:0] sum_up;
  logic [8:0] sum_dn;
  logic [7:0] next_pos;

  assign hs_rise = hsync & ~hsync_q;
  assign vs_rise = vsync & ~vsync_q;

  assign act_left  = player2 ? p2_left  : p1_left;
  assign act_right = player2 ? p2_right : p1_right;
  assign act_mode  = player2 ? p2_mode  : p1_mode;
  assign act_abs   = player2 ? p2_abs   : p1_abs;
  assign act_pos   = player2 ? p2_pos   : p1_pos;

  assign base_step = speed ? {1'b0, STEP_FAST}
                           : {1'b0, STEP_SLOW};

`ifdef PADDLE_ACCEL_EN
  localparam logic [5:0] ACCEL_FRAMES = 6'd12;

  logic [5:0] hold_cnt;
  logic       hold_dir;
  logic       player2_q;

  assign step = (hold_cnt == ACCEL_FRAMES)
              ? {base_step[3:0], 1'b0}
              : base_step;

  // Counts frames of one held direction; a new direction starts at 1.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_cnt  <= 6'd0;
      hold_dir  <= 1'b0;
      player2_q <= 1'b0;
    end else begin
      player2_q <= player2;
      if (player2 != player2_q) begin
        hold_cnt <= 6'd0;
      end else if (vs_rise) begin
        if (act_left ^ act_right) begin
          hold_dir <= act_left;
          if (hold_cnt == 6'd0 || hold_dir == act_left) begin
            if (hold_cnt != ACCEL_FRAMES)
              hold_cnt <= hold_cnt + 6'd1;
          end else begin
            hold_cnt <= 6'd1;
          end
        end else begin
          hold_cnt <= 6'd0;
        end
      end
    end
  end
`else
  assign step = base_step;
`endif

  assign sum_up = {1'b0, act_pos} + {4'b0, step};
  assign sum_dn = {1'b0, act_pos} - {4'b0, step};

  always_comb begin
    next_pos = act_pos;
    if (act_left && !act_right)
      next_pos = sum_up[8] ? 8'hFF : sum_up[7:0];
    else if (act_right && !act_left)
      next_pos = sum_dn[8] ? 8'h00 : sum_dn[7:0];
  end

  always_comb begin
    unique case (act_mode)
      2'd0: target = act_pos;
      2'd1: target = act_abs;
      2'd2: target = ~act_abs;
      2'd3: target = CENTER;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      p1_pos      <= CENTER;
      p2_pos      <= CENTER;
      line_cnt    <= 8'd0;
      latched_pos <= CENTER;
      pad_out     <= 1'b0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      if (vs_rise) begin
        if (player2) p2_pos <= next_pos;
        else         p1_pos <= next_pos;
      end
      if (!pad_en_n)
        latched_pos <= target;
      if (!pad_en_n)
        line_cnt <= 8'd0;
      else if (hs_rise && line_cnt != 8'hFF)
        line_cnt <= line_cnt + 8'd1;
      pad_out <= (line_cnt < latched_pos);
    end
  end

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Scoreboard bench for paddle_position_ctrl: a per-cycle reference
// model pushes expected outputs, a monitor pops and compares them.
module tb_paddle_position_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset, hsync, vsync, pad_en_n, player2, speed;
  logic       p1_left, p1_right, p2_left, p2_right;
  logic [1:0] p1_mode, p2_mode;
  logic [7:0] p1_abs, p2_abs;
  logic       pad_out;
  logic [7:0] p1_pos, p2_pos;

  always #5 clk_sys = ~clk_sys;

  paddle_position_ctrl dut (
    .clk_sys(clk_sys), .reset(reset), .hsync(hsync), .vsync(vsync),
    .pad_en_n(pad_en_n), .player2(player2), .speed(speed),
    .p1_left(p1_left), .p1_right(p1_right),
    .p2_left(p2_left), .p2_right(p2_right),
    .p1_mode(p1_mode), .p2_mode(p2_mode),
    .p1_abs(p1_abs), .p2_abs(p2_abs),
    .pad_out(pad_out), .p1_pos(p1_pos), .p2_pos(p2_pos)
  );

  typedef struct {
    logic       pad;
    logic [7:0] p1;
    logic [7:0] p2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  // Reference state, plain integers.
  int m_p1, m_p2, m_cnt, m_lat, m_pad, m_hq, m_vq;
  int m_run, m_rdir, m_plq;

  function automatic int clamp255(int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic model_step();
    int hr, vr, act, mode, absv, tgt, dir, stp, np;
    if (reset) begin
      m_p1 = 114; m_p2 = 114; m_cnt = 0; m_lat = 114;
      m_pad = 0; m_hq = 0; m_vq = 0; m_run = 0; m_rdir = 0; m_plq = 0;
    end else begin
      hr   = (hsync && m_hq == 0) ? 1 : 0;
      vr   = (vsync && m_vq == 0) ? 1 : 0;
      act  = player2 ? m_p2 : m_p1;
      mode = player2 ? int'(p2_mode) : int'(p1_mode);
      absv = player2 ? int'(p2_abs) : int'(p1_abs);
      dir  = player2 ? (int'(p2_left) - int'(p2_right))
                     : (int'(p1_left) - int'(p1_right));
      case (mode)
        0:       tgt = act;
        1:       tgt = absv;
        2:       tgt = 255 - absv;
        default: tgt = 114;
      endcase
      np = (m_cnt < m_lat) ? 1 : 0;
      stp = speed ? 8 : 4;
`ifdef PADDLE_ACCEL_EN
      if (m_run == 12) stp = stp * 2;
      if (int'(player2) != m_plq) m_run = 0;
      else if (vr == 1) begin
        if (dir != 0) begin
          if (m_run == 0 || dir == m_rdir) m_run = (m_run < 12) ? m_run + 1 : 12;
          else m_run = 1;
          m_rdir = dir;
        end else m_run = 0;
      end
      m_plq = int'(player2);
`endif
      if (vr == 1) begin
        if (player2) m_p2 = clamp255(act + dir * stp);
        else         m_p1 = clamp255(act + dir * stp);
      end
      if (!pad_en_n) begin
        m_lat = tgt;
        m_cnt = 0;
      end else if (hr == 1) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      m_pad = np;
      m_hq = int'(hsync);
      m_vq = int'(vsync);
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.pad = (m_pad != 0);
    e.p1  = 8'(m_p1);
    e.p2  = 8'(m_p2);
    exp_q.push_back(e);
    @(negedge clk_sys);
  endtask

  // Monitor: outputs are presented every cycle, sampled after the edge.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk_sys);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (pad_out !== e.pad || p1_pos !== e.p1 || p2_pos !== e.p2) begin
          n_bad++;
          $display("FAIL outputs @%0t: got pad=%b p1=%0d p2=%0d, want pad=%b p1=%0d p2=%0d",
                   $time, pad_out, p1_pos, p2_pos, e.pad, e.p1, e.p2);
        end
      end
    end
  end

  bit rnd_mode;

  task automatic line();
    hsync = 1'b1; tick();
    hsync = 1'b0; tick();
    if (rnd_mode && ($urandom % 8 == 0)) p1_abs = 8'($urandom);
    if (rnd_mode && ($urandom % 8 == 0)) p2_abs = 8'($urandom);
  endtask

  task automatic frame(int lines, bit allow_rst);
    int rst_at;
    rst_at = allow_rst && ($urandom % 6 == 0) ? int'($urandom_range(1, lines)) : -1;
    vsync = 1'b1;
    hsync = rnd_mode ? 1'($urandom) : 1'b0;
    tick();
    hsync = 1'b0; tick();
    vsync = 1'b0;
    pad_en_n = 1'b0;
    hsync = 1'b1; tick();
    hsync = 1'b0; tick();
    tick();
    pad_en_n = 1'b1;
    for (int i = 0; i < lines; i++) begin
      line();
      if (i == rst_at) begin
        reset = 1'b1; tick();
        reset = 1'b0;
      end
    end
    pad_en_n = 1'b0;
    tick();
  endtask

  task automatic set_dirs(bit l1, bit r1, bit l2, bit r2);
    p1_left = l1; p1_right = r1; p2_left = l2; p2_right = r2;
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b0; vsync = 1'b0; pad_en_n = 1'b0;
    player2 = 1'b0; speed = 1'b0; rnd_mode = 1'b0;
    set_dirs(0, 0, 0, 0);
    p1_mode = 2'd0; p2_mode = 2'd0; p1_abs = 8'd0; p2_abs = 8'd0;
    @(negedge clk_sys);
    repeat (3) tick();
    reset = 1'b0;

    repeat (3) frame(130, 0);

    set_dirs(1, 0, 0, 0);
    repeat (40) frame(10, 0);
    frame(260, 0);

    player2 = 1'b1; speed = 1'b1;
    set_dirs(0, 0, 0, 1);
    repeat (30) frame(20, 0);
    frame(40, 0);

    player2 = 1'b0; speed = 1'b0;
    set_dirs(0, 0, 0, 0);
    p1_mode = 2'd2; p1_abs = 8'h20;
    frame(10, 0);
    pad_en_n = 1'b1;
    for (int i = 0; i < 240; i++) begin
      if (i == 50) p1_abs = 8'h00;
      line();
    end
    pad_en_n = 1'b0; tick();

    p1_mode = 2'd1; p1_abs = 8'hFF;
    frame(300, 0);
    p1_mode = 2'd1; p1_abs = 8'h00;
    frame(30, 0);

    // Randomized frames, controls, modes and mid-frame resets.
    rnd_mode = 1'b1;
    p1_mode = 2'd0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom % 3 == 0) player2 = 1'($urandom);
      if ($urandom % 4 == 0) speed = 1'($urandom);
      if ($urandom % 3 == 0)
        set_dirs(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom % 4 == 0) p1_mode = 2'($urandom);
      if ($urandom % 4 == 0) p2_mode = 2'($urandom);
      frame(int'($urandom_range(20, 280)), 1);
    end

    repeat (3) tick();
    @(negedge clk_sys);
    @(negedge clk_sys);
    done = 1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
